// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - scoreboard hazard unit: ID stall, operand forwarding, HI/LO busy, flushes
module hazard_sb #(
   parameter  int NREG    = 32,
   parameter  int MUL_LAT = 4,
   parameter  int DIV_LAT = 16,
   localparam int AW      = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic          id_wen,
   input  logic [AW-1:0] id_rd,
   input  logic [1:0]    id_rdy,
   input  logic          id_md_use,
   input  logic          id_md_start,
   input  logic          id_md_div,
   input  logic          exc,
   input  logic          eret,
   output logic          stall,
   output logic [1:0]    fwd_rs,
   output logic [1:0]    fwd_rt,
   output logic          flush_id,
   output logic          flush_ex,
   output logic          flush_mem,
   output logic          md_busy,
   output logic [31:0]   stall_cnt
);

   localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int MW     = $clog2(MD_MAX + 1);

   // pos: 0 = idle, 1/2/3 = newest writer sits in EX/MEM/WB; rdy: stage that first holds its result
   logic [1:0]    pos [NREG];
   logic [1:0]    rdy [NREG];
   logic [MW-1:0] md_cnt;

   logic          live_rs, live_rt;
   logic          haz_rs, haz_rt;
   logic          id_fire;
   logic [1:0]    issue_rdy;

   always_comb begin
      live_rs = id_use_rs && (id_rs != '0) && (pos[id_rs] != 2'd0);
      live_rt = id_use_rt && (id_rt != '0) && (pos[id_rt] != 2'd0);
      haz_rs  = live_rs && (pos[id_rs] < rdy[id_rs]);
      haz_rt  = live_rt && (pos[id_rt] < rdy[id_rt]);
      fwd_rs  = (live_rs && !haz_rs) ? pos[id_rs] : 2'd0;
      fwd_rt  = (live_rt && !haz_rt) ? pos[id_rt] : 2'd0;
   end

   assign md_busy   = (md_cnt != '0);
   assign stall     = id_valid & ~exc & ~eret & (haz_rs | haz_rt | (id_md_use & md_busy));
   assign id_fire   = id_valid & ~stall & ~exc & ~eret;
   assign issue_rdy = (id_rdy == 2'd0) ? 2'd1 : id_rdy;

   assign flush_id  = exc | eret;
   assign flush_ex  = exc;
   assign flush_mem = exc;

   // Register 0 is never written here, so its entry stays at its reset value of 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            pos[r] <= 2'd0;
            rdy[r] <= 2'd0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (id_fire && id_wen && (id_rd == AW'(r))) begin
               pos[r] <= 2'd1;
               rdy[r] <= issue_rdy;
            end else if (exc && ((pos[r] == 2'd1) || (pos[r] == 2'd2))) begin
               pos[r] <= 2'd0;
            end else if (pos[r] == 2'd3) begin
               pos[r] <= 2'd0;
            end else if (pos[r] != 2'd0) begin
               pos[r] <= pos[r] + 2'd1;
            end
         end
      end
   end

   // An issued multiply/divide runs to completion even across an exception.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt <= '0;
      end else if (id_fire && id_md_start) begin
         md_cnt <= id_md_div ? MW'(DIV_LAT) : MW'(MUL_LAT);
      end else if (md_busy) begin
         md_cnt <= md_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 32'd0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - self-checking bench for hazard_sb against a cycle-stamp reference model
module tb_hazard_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_use_rs, id_use_rt, id_wen;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [1:0]  id_rdy;
   logic        id_md_use, id_md_start, id_md_div, exc, eret;
   logic        stall, flush_id, flush_ex, flush_mem, md_busy;
   logic [1:0]  fwd_rs, fwd_rt;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   hazard_sb #(.NREG(32), .MUL_LAT(4), .DIV_LAT(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_rd(id_rd),
      .id_rdy(id_rdy), .id_md_use(id_md_use), .id_md_start(id_md_start),
      .id_md_div(id_md_div), .exc(exc), .eret(eret), .stall(stall), .fwd_rs(fwd_rs),
      .fwd_rt(fwd_rt), .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   int          tests = 0;
   int          fails = 0;
   // Model: cycle at which the newest writer of each register issued, its ready stage, and
   // the last cycle the HI/LO unit stays busy.
   int          cyc;
   int          last_iss [32];
   int          m_rdy [32];
   int          md_end;
   int unsigned scnt;
   bit          e_stall, e_fire;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int r = 0; r < 32; r++) begin
         last_iss[r] = -1000;
         m_rdy[r]    = 1;
      end
      md_end  = -1;
      scnt    = 0;
      e_stall = 1'b0;
      e_fire  = 1'b0;
   endtask

   task automatic src_model(input logic use_s, input int s, output bit hz, output int fw);
      int age;
      hz  = 1'b0;
      fw  = 0;
      age = cyc - last_iss[s];
      if (use_s && s != 0 && age >= 1 && age <= 3) begin
         if (age < m_rdy[s]) hz = 1'b1;
         else                fw = age;
      end
   endtask

   task automatic eval_check();
      bit hz_rs, hz_rt, busy;
      int fw_rs, fw_rt;
      src_model(id_use_rs, int'(id_rs), hz_rs, fw_rs);
      src_model(id_use_rt, int'(id_rt), hz_rt, fw_rt);
      busy    = (cyc <= md_end);
      e_stall = id_valid && !exc && !eret && (hz_rs || hz_rt || (id_md_use && busy));
      e_fire  = id_valid && !e_stall && !exc && !eret;
      chk("stall", 32'(stall), 32'(e_stall));
      if (!hz_rs) chk("fwd_rs", 32'(fwd_rs), fw_rs);
      if (!hz_rt) chk("fwd_rt", 32'(fwd_rt), fw_rt);
      chk("flush_id", 32'(flush_id), 32'(exc | eret));
      chk("flush_ex", 32'(flush_ex), 32'(exc));
      chk("flush_mem", 32'(flush_mem), 32'(exc));
      chk("md_busy", 32'(md_busy), 32'(busy));
      chk("stall_cnt", stall_cnt, scnt);
   endtask

   task automatic advance();
      int age;
      if (e_stall && scnt != 32'hFFFF_FFFF) scnt++;
      if (exc) begin
         for (int r = 0; r < 32; r++) begin
            age = cyc - last_iss[r];
            if (age == 1 || age == 2) last_iss[r] = -1000;
         end
      end
      if (e_fire && id_wen && id_rd != 5'd0) begin
         last_iss[id_rd] = cyc;
         m_rdy[id_rd]    = (id_rdy == 2'd0) ? 1 : int'(id_rdy);
      end
      if (e_fire && id_md_start) md_end = cyc + (id_md_div ? 16 : 4);
      cyc++;
   endtask

   task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit wen, input logic [4:0] rd,
                        input logic [1:0] rdy, input bit mdu, input bit mds, input bit mdd,
                        input bit ex, input bit er);
      @(posedge clk);
      advance();
      @(negedge clk);
      id_valid = v;   id_rs = rs;     id_rt = rt;       id_use_rs = urs; id_use_rt = urt;
      id_wen = wen;   id_rd = rd;     id_rdy = rdy;     id_md_use = mdu;
      id_md_start = mds; id_md_div = mdd; exc = ex;     eret = er;
      #1;
      eval_check();
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_wen = 0;
      id_rd = 0; id_rdy = 0; id_md_use = 0; id_md_start = 0; id_md_div = 0; exc = 0; eret = 0;
      model_reset();
      #12;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_fwd_rs", 32'(fwd_rs), 0);
      chk("rst_md_busy", 32'(md_busy), 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush", 32'({flush_id, flush_ex, flush_mem}), 0);
      rst_n = 1'b1;

      // ALU chain on r5
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0);
      drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_t1_fwd", 32'(fwd_rs), 1);
      drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_t2_fwd", 32'(fwd_rs), 2);
      nop(); nop(); nop();

      // Load-use on r7
      drive(1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0);
      drive(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_stall", 32'(stall), 1);
      drive(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_release", 32'({stall, fwd_rt}), 32'({1'b0, 2'd2}));
      chk("lu_cnt", stall_cnt, 1);
      nop(); nop(); nop();

      // Late result (mfc0 r3)
      drive(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0);
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("late_s1", 32'(stall), 1);
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("late_s2", 32'(stall), 1);
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("late_fwd3", 32'({stall, fwd_rs}), 32'({1'b0, 2'd3}));
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("late_fwd0", 32'(fwd_rs), 0);

      // Multiply then mflo
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         drive(1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0);
         chk("mul_stall", 32'({stall, md_busy}), 32'(2'b11));
      end
      drive(1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0);
      chk("mul_issue", 32'({stall, md_busy}), 0);
      nop(); nop(); nop();

      // Exception with r4 in WB and r9 in EX
      drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);
      nop();
      drive(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0);
      drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("exc_flush", 32'({flush_id, flush_ex, flush_mem, stall}), 32'(4'b1110));
      drive(1, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("exc_after", 32'({stall, fwd_rs, fwd_rt}), 0);

      // eret flushes ID only
      drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 1);
      chk("eret_flush", 32'({flush_id, flush_ex, flush_mem}), 32'(3'b100));
      nop(); nop(); nop();

      // Asynchronous reset in the middle of a load-use stall with the multiplier busy
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0);
      drive(1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mid_pre", 32'({stall, md_busy}), 32'(2'b11));
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_busy", 32'(md_busy), 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      chk("mid_rst_fwd", 32'({fwd_rs, fwd_rt}), 0);
      model_reset();
      id_valid = 0; id_use_rs = 0; id_use_rt = 0;
      rst_n = 1'b1;
      #1;
      eval_check();

      // Randomized traffic over a small register window to keep hazards dense
      for (int n = 0; n < 3000; n++) begin
         bit st;
         st = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               st || ($urandom_range(0, 5) == 0), st, $urandom_range(0, 3) == 0,
               $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised scoreboard hazard unit for the 5-stage MIPS pipeline. It supersedes purely combinational register-compare hazard detection. It tracks every in-flight GPR write by pipeline position and result-ready stage, and produces ID-stage stall and operand-forwarding selects from that state. It also owns the multiply/divide busy counter and the exception/eret flush outputs. It sits beside the ID stage and is fed by the decoder and the CP0 exception logic.

## Interface
Parameters:
- NREG, 32, number of GPRs; AW = $clog2(NREG), derived.
- MUL_LAT, 4, multiply latency in cycles.
- DIV_LAT, 16, divide latency in cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register numbers.
- id_use_rs, id_use_rt  in  1  the source is actually read.
- id_wen  in  1  ID instruction writes a GPR.
- id_rd  in  AW  destination register.
- id_rdy  in  2  stage whose output first holds the result: 1 = EX (ALU), 2 = MEM (load), 3 = WB (mfc0/late). A value of 0 is treated as 1.
- id_md_use  in  1  ID instruction touches HI/LO (mult, div, mf*, mt*).
- id_md_start  in  1  ID instruction starts a multiply or divide.
- id_md_div  in  1  1 = divide, 0 = multiply; valid with id_md_start.
- exc  in  1  exception taken in MEM this cycle.
- eret  in  1  eret in ID this cycle.
- stall  out  1  hold IF/ID and insert a bubble into EX.
- fwd_rs, fwd_rt  out  2  ID operand source: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
- flush_id, flush_ex, flush_mem  out  1  clear the named pipeline register.
- md_busy  out  1  the HI/LO unit is busy.
- stall_cnt  out  32  saturating count of stall cycles.

## Operation
- State held per register r (r = 1..NREG-1):
  - pos[r] (2 b): 0 = no in-flight writer; 1/2/3 = newest writer is in EX/MEM/WB.
  - rdy[r] (2 b): the ready stage latched from id_rdy.
- Register 0 is never tracked. id_wen with rd = 0 is ignored. A source equal to 0 yields fwd = 0 and never stalls.
- id_fire = id_valid & !stall & !exc & !eret.
- On id_fire & id_wen: pos[rd] <= 1, rdy[rd] <= id_rdy. Issue overrides advance for the same register.
- Every other tracked entry advances every cycle, stalled or not: pos 1 -> 2 -> 3 -> 0.
- Source hazard for src s (used, s != 0, pos[s] != 0):
  - pos[s] < rdy[s]: stall.
  - otherwise: fwd_s = pos[s].
  - Untracked source: fwd_s = 0 (regfile is written in WB and is readable the next cycle).
- md counter (md_cnt):
  - On id_fire & id_md_start: load DIV_LAT or MUL_LAT.
  - Otherwise, decrement while nonzero.
  - md_busy = (md_cnt != 0).
  - Exceptions do not abort an issued operation.
- stall = id_valid & !exc & !eret & (any source hazard | (id_md_use & md_busy)).
- On exc:
  - flush_id = flush_ex = flush_mem = 1.
  - Every entry with pos 1 or 2 is cleared to 0 in the same edge; pos 3 entries retire normally.
  - stall is forced to 0.
- On eret (without exc): flush_id = 1 only. State is untouched apart from normal advance.
- stall_cnt increments on every cycle with stall = 1 and saturates at 0xFFFFFFFF.

## Timing
- Reset (rst_n low, asynchronous): all pos/rdy = 0, md_cnt = 0, stall_cnt = 0.
  - Consequently stall = 0, fwd_rs = fwd_rt = 0 and md_busy = 0.
  - Flush outputs follow exc/eret combinationally (0 when both are low).
- stall, fwd_*, and flush_* are combinational from the current inputs and state. All state updates occur on the clk rising edge.
- Dependent instruction with producer id_rdy = k issued at cycle t:
  - The consumer in ID at t+1 stalls k-1 cycles.
  - It then issues with fwd = k.
- Back-to-back writers to the same register: the newest one wins pos/rdy. The older one is still written in WB before the newer one reaches WB.
- Multiply issued at t: md_busy is high for cycles t+1 .. t+MUL_LAT. A HI/LO consumer issues at t+MUL_LAT+1.
- exc and id_md_start in the same cycle: the counter does not load, because id_fire = 0.

## Test plan
- ALU chain: issue add r5 (rdy=1) at t; at t+1 ID reads rs = r5 -> stall = 0, fwd_rs = 1. At t+2 a reader of r5 gets fwd_rs = 2.
- Load-use: lw r7 (rdy=2) at t; reader of r7 at t+1 -> stall = 1 for one cycle, then at t+2 stall = 0, fwd_rt = 2, stall_cnt = 1.
- Late result: mfc0 r3 (rdy=3) -> dependent stalls 2 cycles, then fwd = 3. At t+4 the same reader gets fwd = 0.
- Multiply: mult issued at t with MUL_LAT = 4; mflo in ID from t+1 -> stall for t+1..t+4, issues at t+5, md_busy falls at t+5.
- Exception: r9 writer at pos 1 and r4 writer at pos 3, assert exc -> flush_id/ex/mem = 1, stall = 0. Next cycle a reader of r9 gets fwd = 0 with no stall; the r4 entry is 0.
- Reset mid-stall: during the load-use stall, pull rst_n low -> stall, md_busy, stall_cnt and fwd_* all 0 immediately, without waiting for a clock edge.
